// File: rtl/bcd_pkg.sv
// Shared types and limits for the BCD scan counter: one BCD digit and its legal range.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_scan_cntr_if.sv
// Control and display bus of the BCD scan counter: count requests in, one scanned digit out.
interface bcd_scan_cntr_if #(
    parameter int NUM_DIGITS = 4
);
    import bcd_pkg::*;

    logic                  clr;
    logic                  inc;
    logic                  dec;
    logic                  blank_en;
    bcd_t                  num;
    logic                  dis;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic                  ovf;
    logic                  unf;

    modport master (
        output clr, inc, dec, blank_en,
        input  num, dis, dig_sel, ovf, unf
    );

    modport slave (
        input  clr, inc, dec, blank_en,
        output num, dis, dig_sel, ovf, unf
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit with ripple carry/borrow: steps only when cin is high, wraps 9<->0 and reports it on cout.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic up,
    input  logic dn,
    input  logic cin,
    output bcd_t value,
    output logic cout
);

    bcd_t r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= BCD_MIN;
        end else if (clr) begin
            r_value <= BCD_MIN;
        end else if (cin && up) begin
            r_value <= (r_value == BCD_MAX) ? BCD_MIN : r_value + 4'd1;
        end else if (cin && dn) begin
            r_value <= (r_value == BCD_MIN) ? BCD_MAX : r_value - 4'd1;
        end
    end

    // Combinational so the whole chain ripples within the same cycle.
    assign cout  = cin & ((up & (r_value == BCD_MAX)) | (dn & (r_value == BCD_MIN)));
    assign value = r_value;

endmodule

// File: rtl/bcd_scan_cntr.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit scanner,
// leading-zero blanking and wrap pulses.
module bcd_scan_cntr
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_scan_cntr_if.slave  bus
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    logic                  w_up;
    logic                  w_dn;
    logic [NUM_DIGITS:0]   w_carry;
    bcd_t                  w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_zero_run;

    logic [SCAN_W-1:0]     r_scan;
    logic [IDX_W-1:0]      r_idx;
    bcd_t                  r_num;
    logic                  r_dis;
    logic [NUM_DIGITS-1:0] r_dig_sel;
    logic                  r_ovf;
    logic                  r_unf;

    // inc and dec together cancel out.
    assign w_up       = bus.inc & ~bus.dec;
    assign w_dn       = bus.dec & ~bus.inc;
    assign w_carry[0] = w_up | w_dn;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (bus.clr),
            .up    (w_up),
            .dn    (w_dn),
            .cin   (w_carry[g]),
            .value (w_digit[g]),
            .cout  (w_carry[g+1])
        );
    end

    // Digit k blanks when it and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run & (w_digit[k] == BCD_MIN);
            w_blank[k] = w_zero_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    // num, dis and dig_sel all sample the same index so they stay consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num     <= BCD_MIN;
            r_dis     <= 1'b1;
            r_dig_sel <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_num     <= w_digit[r_idx];
            r_dis     <= bus.blank_en & w_blank[r_idx];
            r_dig_sel <= NUM_DIGITS'(1) << r_idx;
            r_ovf     <= ~bus.clr & w_up & w_carry[NUM_DIGITS];
            r_unf     <= ~bus.clr & w_dn & w_carry[NUM_DIGITS];
        end
    end

    assign bus.num     = r_num;
    assign bus.dis     = r_dis;
    assign bus.dig_sel = r_dig_sel;
    assign bus.ovf     = r_ovf;
    assign bus.unf     = r_unf;

endmodule

// File: tb/tb_bcd_scan_cntr.sv
// Directed bench for bcd_scan_cntr with NUM_DIGITS=4, SCAN_DIV=4.
module tb_bcd_scan_cntr;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    bcd_scan_cntr_if #(.NUM_DIGITS(4)) bus ();

    bcd_scan_cntr #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture one full frame, placing each sample by its dig_sel bit.
    task automatic check_frame(input string tag, input logic [15:0] exp_num, input logic [3:0] exp_dis);
        logic [15:0] got_num;
        logic [3:0]  got_dis;
        logic [3:0]  seen;
        got_num = 'x;
        got_dis = 'x;
        seen    = '0;
        for (int c = 0; c < 16; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (bus.dig_sel[i] === 1'b1) begin
                    got_num[i*4 +: 4] = bus.num;
                    got_dis[i]        = bus.dis;
                    seen[i]           = 1'b1;
                end
            end
        end
        check({tag, " seen"}, 32'(seen), 32'hF);
        check({tag, " num"}, 32'(got_num), 32'(exp_num));
        check({tag, " dis"}, 32'(got_dis), 32'(exp_dis));
    endtask

    task automatic pulse_inc();
        bus.inc = 1'b1;
        step();
        bus.inc = 1'b0;
    endtask

    task automatic pulse_dec();
        bus.dec = 1'b1;
        step();
        bus.dec = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.clr      = 1'b0;
        bus.inc      = 1'b0;
        bus.dec      = 1'b0;
        bus.blank_en = 1'b0;

        // Reset state and release
        repeat (2) step();
        check("rst num", 32'(bus.num), 32'h0);
        check("rst dis", 32'(bus.dis), 32'h1);
        check("rst dig_sel", 32'(bus.dig_sel), 32'h0);
        check("rst ovf", 32'(bus.ovf), 32'h0);
        check("rst unf", 32'(bus.unf), 32'h0);
        rst_n = 1'b1;
        step();
        check("rel dig_sel", 32'(bus.dig_sel), 32'h1);
        check("rel num", 32'(bus.num), 32'h0);
        check("rel dis", 32'(bus.dis), 32'h0);

        // Scan timing: first edge after release was cycle 1 of digit 0
        for (int k = 0; k < 16; k++) begin
            step();
            check("scan dig_sel", 32'(bus.dig_sel), 32'(4'b0001 << (((k + 1) / 4) % 4)));
        end

        // Underflow 0000 -> 9999, then overflow back
        pulse_dec();
        check("unf pulse", 32'(bus.unf), 32'h1);
        check("unf ovf quiet", 32'(bus.ovf), 32'h0);
        step();
        check("unf clear", 32'(bus.unf), 32'h0);
        check_frame("f9999", 16'h9999, 4'b0000);
        pulse_inc();
        check("ovf pulse", 32'(bus.ovf), 32'h1);
        check("ovf unf quiet", 32'(bus.unf), 32'h0);
        step();
        check("ovf clear", 32'(bus.ovf), 32'h0);
        check_frame("f0000", 16'h0000, 4'b0000);

        // Carry chain around 0099
        bus.inc = 1'b1;
        repeat (99) step();
        bus.inc = 1'b0;
        check_frame("f0099", 16'h0099, 4'b0000);
        pulse_inc();
        check("c100 ovf", 32'(bus.ovf), 32'h0);
        check("c100 unf", 32'(bus.unf), 32'h0);
        check_frame("f0100", 16'h0100, 4'b0000);
        pulse_dec();
        check("b099 ovf", 32'(bus.ovf), 32'h0);
        check("b099 unf", 32'(bus.unf), 32'h0);
        check_frame("f0099b", 16'h0099, 4'b0000);

        // Blanking
        pulse_clr();
        bus.blank_en = 1'b1;
        check_frame("blank0000", 16'h0000, 4'b1110);
        bus.inc = 1'b1;
        repeat (40) step();
        bus.inc = 1'b0;
        check_frame("blank0040", 16'h0040, 4'b1100);
        bus.blank_en = 1'b0;
        check_frame("noblank0040", 16'h0040, 4'b0000);

        // Simultaneous inc and dec hold the count
        pulse_clr();
        bus.inc = 1'b1;
        repeat (5) step();
        bus.dec = 1'b1;
        step();
        check("incdec ovf", 32'(bus.ovf), 32'h0);
        check("incdec unf", 32'(bus.unf), 32'h0);
        bus.inc = 1'b0;
        bus.dec = 1'b0;
        check_frame("f0005", 16'h0005, 4'b0000);

        // clr beats inc at 9999 and suppresses ovf
        pulse_clr();
        pulse_dec();
        step();
        bus.clr = 1'b1;
        bus.inc = 1'b1;
        step();
        bus.clr = 1'b0;
        bus.inc = 1'b0;
        check("clr ovf", 32'(bus.ovf), 32'h0);
        step();
        check("clr ovf late", 32'(bus.ovf), 32'h0);
        check_frame("fclr", 16'h0000, 4'b0000);

        // Asynchronous reset mid-count, mid-cycle
        bus.inc = 1'b1;
        repeat (3) step();
        bus.inc = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst num", 32'(bus.num), 32'h0);
        check("arst dis", 32'(bus.dis), 32'h1);
        check("arst dig_sel", 32'(bus.dig_sel), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("arst rel dig_sel", 32'(bus.dig_sel), 32'h1);
        check_frame("farst", 16'h0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
